// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM encoding,
// default geometry and a pointer-width helper for the return stack.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_e;

    localparam int DEF_ADDR_W      = 5;
    localparam int DEF_STACK_DEPTH = 4;

    // A single-entry stack still needs a one-bit index.
    function automatic int stack_ptr_w(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/pc_stack.sv
// LIFO of return addresses. Entries are never cleared; only the level
// register decides what is visible, so stale contents can never be popped.
module pc_stack
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_W-1:0]                  push_data,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   level,
    output logic [ADDR_W-1:0]                  top
);

    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = stack_ptr_w(STACK_DEPTH);

    logic [ADDR_W-1:0] mem_r [STACK_DEPTH];
    logic [LVL_W-1:0]  level_r;
    logic [PTR_W-1:0]  wr_ptr_s;
    logic [PTR_W-1:0]  rd_ptr_s;

    assign full     = (level_r == LVL_W'(STACK_DEPTH));
    assign empty    = (level_r == {LVL_W{1'b0}});
    assign wr_ptr_s = PTR_W'(level_r);
    assign rd_ptr_s = PTR_W'(level_r - LVL_W'(1));
    assign level    = level_r;
    assign top      = mem_r[rd_ptr_s];

    // Occupancy counter; soft clear empties the stack logically.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= {LVL_W{1'b0}};
        end else if (clr) begin
            level_r <= {LVL_W{1'b0}};
        end else if (push && !full) begin
            level_r <= level_r + LVL_W'(1);
        end else if (pop && !empty) begin
            level_r <= level_r - LVL_W'(1);
        end else begin
            level_r <= level_r;
        end
    end

    // Entry storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !full && !clr) begin
            mem_r[wr_ptr_s] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: IDLE/RUN/HALT control with jump, branch,
// call/return and a sticky stack error flag. One action per PCLK edge.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int LAST_ADDR   = 2**ADDR_W - 1
) (
    input  logic                               PCLK,
    input  logic                               PRESETn,
    input  logic                               load_done,
    input  logic                               stall,
    input  logic                               restart,
    input  logic                               jump_en,
    input  logic                               branch_en,
    input  logic                               cond_flag,
    input  logic                               call_en,
    input  logic                               ret_en,
    input  logic [ADDR_W-1:0]                  target_addr,
    output logic [ADDR_W-1:0]                  pc,
    output logic                               halted,
    output logic                               stack_err,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level
);

    seq_state_e        state_r;
    seq_state_e        state_next_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] stk_top_s;
    logic              halted_r;
    logic              stack_err_r;
    logic              err_set_s;
    logic              push_s;
    logic              pop_s;
    logic              clr_s;
    logic              stk_full_s;
    logic              stk_empty_s;
    logic              at_last_s;
    logic              run_act_s;

    assign pc_inc_s  = pc_r + ADDR_W'(1);
    assign at_last_s = (pc_r == ADDR_W'(LAST_ADDR));
    // An instruction executes only in RUN, enabled, unstalled and not at the halt address.
    assign run_act_s = (state_r == ST_RUN) && load_done && !stall && !at_last_s;

    pc_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .clr       (clr_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .full      (stk_full_s),
        .empty     (stk_empty_s),
        .level     (stack_level),
        .top       (stk_top_s)
    );

    // FSM state register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: restart dominates, HALT is absorbing, stall freezes.
    always_comb begin
        state_next_s = state_r;
        if (restart) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!stall && load_done) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!stall && load_done && at_last_s) begin
                        state_next_s = ST_HALT;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_HALT: state_next_s = ST_HALT;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: select the single action for this edge in priority order.
    always_comb begin
        pc_next_s = pc_r;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        err_set_s = 1'b0;
        clr_s     = 1'b0;
        if (restart) begin
            clr_s     = 1'b1;
            pc_next_s = {ADDR_W{1'b0}};
        end else if (run_act_s) begin
            if (ret_en) begin
                if (!stk_empty_s) begin
                    pop_s     = 1'b1;
                    pc_next_s = stk_top_s;
                end else begin
                    err_set_s = 1'b1;
                    pc_next_s = pc_inc_s;
                end
            end else if (call_en) begin
                if (!stk_full_s) begin
                    push_s    = 1'b1;
                    pc_next_s = target_addr;
                end else begin
                    err_set_s = 1'b1;
                    pc_next_s = pc_inc_s;
                end
            end else if (jump_en || (branch_en && cond_flag)) begin
                pc_next_s = target_addr;
            end else begin
                pc_next_s = pc_inc_s;
            end
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Registered datapath outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pc_r        <= {ADDR_W{1'b0}};
            stack_err_r <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            pc_r        <= pc_next_s;
            stack_err_r <= clr_s ? 1'b0 : (stack_err_r | err_set_s);
            halted_r    <= (state_next_s == ST_HALT);
        end
    end

    assign pc        = pc_r;
    assign halted    = halted_r;
    assign stack_err = stack_err_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run compared against a queue-based behavioural model.
module tb_pc_sequencer;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int NPC    = 2**ADDR_W;
    localparam int LAST   = NPC - 1;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic              load_done, stall, restart, jump_en, branch_en;
    logic              cond_flag, call_en, ret_en;
    logic [ADDR_W-1:0] target_addr;
    logic [ADDR_W-1:0] pc;
    logic              halted, stack_err;
    logic [2:0]        stack_level;

    int checks = 0;
    int errors = 0;

    int m_pc;
    int m_mode;
    bit m_err;
    int m_stk[$];

    pc_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .load_done(load_done), .stall(stall),
        .restart(restart), .jump_en(jump_en), .branch_en(branch_en),
        .cond_flag(cond_flag), .call_en(call_en), .ret_en(ret_en),
        .target_addr(target_addr), .pc(pc), .halted(halted),
        .stack_err(stack_err), .stack_level(stack_level)
    );

    always #5 PCLK = ~PCLK;

    task automatic model_reset();
        m_pc = 0;
        m_mode = M_IDLE;
        m_err = 1'b0;
        m_stk.delete();
    endtask

    // Spec-level behaviour for one rising edge, from the current inputs.
    task automatic model_edge();
        int nxt;
        nxt = (m_pc + 1) % NPC;
        if (restart) begin
            model_reset();
        end else if (m_mode == M_HALT || stall) begin
        end else if (m_mode == M_IDLE) begin
            if (load_done) m_mode = M_RUN;
        end else if (!load_done) begin
        end else if (m_pc == LAST) begin
            m_mode = M_HALT;
        end else if (ret_en) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_err = 1'b1; m_pc = nxt; end
        end else if (call_en) begin
            if (m_stk.size() < DEPTH) begin m_stk.push_back(nxt); m_pc = int'(target_addr); end
            else begin m_err = 1'b1; m_pc = nxt; end
        end else if (jump_en || (branch_en && cond_flag)) begin
            m_pc = int'(target_addr);
        end else begin
            m_pc = nxt;
        end
    endtask

    task automatic clear_ctrl();
        stall = 1'b0; restart = 1'b0; jump_en = 1'b0; branch_en = 1'b0;
        cond_flag = 1'b0; call_en = 1'b0; ret_en = 1'b0; target_addr = '0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        load_done = 1'b0;
        clear_ctrl();
        model_reset();
        #12;
        checks++;
        if (pc !== 5'd0 || halted !== 1'b0 || stack_err !== 1'b0 || stack_level !== 3'd0) begin
            errors++;
            $display("FAIL reset: got pc=%0d halted=%0d err=%0d lvl=%0d expected all 0", pc, halted, stack_err, stack_level);
        end
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        checks++;
        if (pc !== 5'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got pc=%0d halted=%0d expected 0 0", pc, halted);
        end
    endtask

    task automatic test_sequential();
        load_done = 1'b1;
        tick();
        for (int i = 0; i <= 3; i++) begin
            checks++;
            if (pc !== 5'(i) || halted !== 1'b0) begin
                errors++;
                $display("FAIL seq_inc: got pc=%0d halted=%0d expected pc=%0d halted=0", pc, halted, i);
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_call_ret();
        jump_en = 1'b1; target_addr = 5'd4; tick();
        jump_en = 1'b0; call_en = 1'b1; target_addr = 5'd20; tick();
        checks++;
        if (pc !== 5'd20 || stack_level !== 3'd1) begin
            errors++;
            $display("FAIL call: got pc=%0d lvl=%0d expected pc=20 lvl=1", pc, stack_level);
        end
        call_en = 1'b0; ret_en = 1'b1; tick();
        ret_en = 1'b0;
        checks++;
        if (pc !== 5'd5 || stack_level !== 3'd0 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL ret: got pc=%0d lvl=%0d err=%0d expected pc=5 lvl=0 err=0", pc, stack_level, stack_err);
        end
    endtask

    task automatic test_overflow();
        logic [ADDR_W-1:0] exp_pc [5];
        exp_pc[0] = 5'd11; exp_pc[1] = 5'd11; exp_pc[2] = 5'd11; exp_pc[3] = 5'd6; exp_pc[4] = 5'd7;
        call_en = 1'b1; target_addr = 5'd10;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (stack_level !== 3'(i > DEPTH ? DEPTH : i) || stack_err !== (i > DEPTH)) begin
                errors++;
                $display("FAIL nest_call%0d: got lvl=%0d err=%0d", i, stack_level, stack_err);
            end
        end
        checks++;
        if (pc !== 5'd11) begin
            errors++;
            $display("FAIL overflow_pc: got pc=%0d expected 11", pc);
        end
        call_en = 1'b0; ret_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (pc !== exp_pc[i] || stack_err !== 1'b1) begin
                errors++;
                $display("FAIL unwind%0d: got pc=%0d err=%0d expected pc=%0d err=1", i, pc, stack_err, exp_pc[i]);
            end
        end
        ret_en = 1'b0;
    endtask

    task automatic test_halt_priority();
        restart = 1'b1; tick();
        restart = 1'b0; tick();
        jump_en = 1'b1; target_addr = 5'd30; tick();
        call_en = 1'b1; ret_en = 1'b1; target_addr = 5'd3; tick();
        checks++;
        if (pc !== 5'd31 || stack_err !== 1'b1 || stack_level !== 3'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL ret_wins: got pc=%0d err=%0d lvl=%0d halted=%0d expected 31 1 0 0", pc, stack_err, stack_level, halted);
        end
        call_en = 1'b0; ret_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (pc !== 5'd31 || halted !== 1'b1) begin
                errors++;
                $display("FAIL halt_hold%0d: got pc=%0d halted=%0d expected 31 1", i, pc, halted);
            end
        end
        jump_en = 1'b0;
    endtask

    task automatic test_restart_branch();
        restart = 1'b1; stall = 1'b1; tick();
        checks++;
        if (pc !== 5'd0 || halted !== 1'b0 || stack_err !== 1'b0 || stack_level !== 3'd0) begin
            errors++;
            $display("FAIL restart: got pc=%0d halted=%0d err=%0d lvl=%0d expected all 0", pc, halted, stack_err, stack_level);
        end
        restart = 1'b0; stall = 1'b0; jump_en = 1'b1; target_addr = 5'd9; tick();
        checks++;
        if (pc !== 5'd0) begin
            errors++;
            $display("FAIL idle_ignores_jump: got pc=%0d expected 0", pc);
        end
        target_addr = 5'd7; tick();
        jump_en = 1'b0; branch_en = 1'b1; cond_flag = 1'b0; target_addr = 5'd2; tick();
        checks++;
        if (pc !== 5'd8) begin
            errors++;
            $display("FAIL branch_not_taken: got pc=%0d expected 8", pc);
        end
        cond_flag = 1'b1; tick();
        checks++;
        if (pc !== 5'd2) begin
            errors++;
            $display("FAIL branch_taken: got pc=%0d expected 2", pc);
        end
        stall = 1'b1; branch_en = 1'b0; tick();
        checks++;
        if (pc !== 5'd2) begin
            errors++;
            $display("FAIL stall: got pc=%0d expected 2", pc);
        end
        clear_ctrl();
    endtask

    task automatic test_async_reset();
        call_en = 1'b1; target_addr = 5'd12; tick();
        target_addr = 5'd20; tick();
        call_en = 1'b0;
        checks++;
        if (stack_level !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset_level: got lvl=%0d expected 2", stack_level);
        end
        #2 PRESETn = 1'b0;
        #1;
        checks++;
        if (pc !== 5'd0 || halted !== 1'b0 || stack_err !== 1'b0 || stack_level !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got pc=%0d halted=%0d err=%0d lvl=%0d expected all 0", pc, halted, stack_err, stack_level);
        end
        #3 PRESETn = 1'b1;
        model_reset();
        tick();
        ret_en = 1'b1; tick();
        ret_en = 1'b0;
        checks++;
        if (pc !== 5'd1 || stack_err !== 1'b1 || stack_level !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_underflow: got pc=%0d err=%0d lvl=%0d expected 1 1 0", pc, stack_err, stack_level);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            restart   = ($urandom_range(0, 39) == 0) || (m_mode == M_HALT && $urandom_range(0, 3) == 0);
            stall     = ($urandom_range(0, 7) == 0);
            load_done = ($urandom_range(0, 9) != 0);
            ret_en    = ($urandom_range(0, 4) == 0);
            call_en   = ($urandom_range(0, 3) == 0);
            jump_en   = ($urandom_range(0, 9) == 0);
            branch_en = ($urandom_range(0, 5) == 0);
            cond_flag = 1'($urandom_range(0, 1));
            target_addr = 5'($urandom_range(0, LAST));
            tick();
            checks++;
            if (pc !== 5'(m_pc) || halted !== (m_mode == M_HALT) ||
                stack_err !== m_err || stack_level !== 3'(m_stk.size())) begin
                errors++;
                $display("FAIL random%0d: got pc=%0d halted=%0d err=%0d lvl=%0d expected pc=%0d halted=%0d err=%0d lvl=%0d",
                         n, pc, halted, stack_err, stack_level, m_pc, (m_mode == M_HALT), m_err, m_stk.size());
            end
        end
        clear_ctrl();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_call_ret();
        test_overflow();
        test_halt_priority();
        test_restart_branch();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
